// File: rtl/pdm_capture.sv
// PDM microphone front end: bit-clock generation, 2-flop input sync, ones-count decimation to 16-bit PCM.
// Optional clip flag output clip_o when PDM_CLIP_DETECT_EN is defined.
module pdm_capture #(
  parameter int CLK_DIV        = 25,
  parameter int DECIMATION     = 128,
  parameter int SETTLE_WINDOWS = 2
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic        pdm_data_i,
  output logic        pdm_clk_o,
  output logic        pdm_lrsel_o,
  output logic [15:0] sample_o,
  output logic        done_o,
  output logic        busy_o
`ifdef PDM_CLIP_DETECT_EN
  ,
  output logic        clip_o
`endif
);

  localparam int LOG2_DEC = $clog2(DECIMATION);
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SET_W    = (SETTLE_WINDOWS > 1) ? $clog2(SETTLE_WINDOWS) : 1;

  localparam int DIV_LAST_I = CLK_DIV - 1;
  localparam int BIT_LAST_I = DECIMATION - 1;
  localparam int SET_LAST_I = SETTLE_WINDOWS - 1;
  localparam int FULL_I     = DECIMATION;

  localparam logic [DIV_W-1:0]    DIV_LAST   = DIV_LAST_I[DIV_W-1:0];
  localparam logic [LOG2_DEC-1:0] BIT_LAST   = BIT_LAST_I[LOG2_DEC-1:0];
  localparam logic [SET_W-1:0]    SET_LAST   = SET_LAST_I[SET_W-1:0];
  localparam logic [LOG2_DEC:0]   FULL_COUNT = FULL_I[LOG2_DEC:0];

  typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;

  state_t              state;
  logic                sync_q1;
  logic                sync_q2;
  logic [DIV_W-1:0]    div_cnt;
  logic [LOG2_DEC-1:0] bit_cnt;
  logic [LOG2_DEC:0]   acc;
  logic [SET_W-1:0]    settle_cnt;

  logic                bit_edge;
  logic                win_end;
  logic [LOG2_DEC:0]   count_next;
  logic [16:0]         scaled;
  logic [15:0]         sample_next;

  // A bit is taken on the system edge where the registered bit clock falls.
  assign bit_edge    = pdm_clk_o && (div_cnt == DIV_LAST);
  assign win_end     = bit_edge && (bit_cnt == BIT_LAST);
  assign count_next  = acc + {{LOG2_DEC{1'b0}}, sync_q2};
  assign scaled      = {{(16 - LOG2_DEC){1'b0}}, count_next} << (16 - LOG2_DEC);
  assign sample_next = scaled[16] ? 16'hFFFF : scaled[15:0];

  assign pdm_lrsel_o = 1'b0;

  // Disable takes priority over everything, including a window ending on the same edge.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state      <= IDLE;
      sync_q1    <= 1'b0;
      sync_q2    <= 1'b0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      acc        <= '0;
      settle_cnt <= '0;
      pdm_clk_o  <= 1'b0;
      sample_o   <= '0;
      done_o     <= 1'b0;
      busy_o     <= 1'b0;
`ifdef PDM_CLIP_DETECT_EN
      clip_o     <= 1'b0;
`endif
    end else begin
      sync_q1 <= pdm_data_i;
      sync_q2 <= sync_q1;
      done_o  <= 1'b0;
      if (!enable_i) begin
        state      <= IDLE;
        busy_o     <= 1'b0;
        pdm_clk_o  <= 1'b0;
        div_cnt    <= '0;
        bit_cnt    <= '0;
        acc        <= '0;
        settle_cnt <= '0;
      end else if (state == IDLE) begin
        state      <= (SETTLE_WINDOWS == 0) ? RUN : SETTLE;
        busy_o     <= 1'b1;
        pdm_clk_o  <= 1'b0;
        div_cnt    <= '0;
        bit_cnt    <= '0;
        acc        <= '0;
        settle_cnt <= '0;
`ifdef PDM_CLIP_DETECT_EN
        clip_o     <= 1'b0;
`endif
      end else begin
        if (div_cnt == DIV_LAST) begin
          div_cnt   <= '0;
          pdm_clk_o <= ~pdm_clk_o;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end

        if (bit_edge) begin
          if (win_end) begin
            bit_cnt <= '0;
            acc     <= '0;
            if (state == RUN) begin
              sample_o <= sample_next;
              done_o   <= 1'b1;
`ifdef PDM_CLIP_DETECT_EN
              if ((count_next == '0) || (count_next == FULL_COUNT)) begin
                clip_o <= 1'b1;
              end
`endif
            end else if (settle_cnt == SET_LAST) begin
              state      <= RUN;
              settle_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt + SET_W'(1);
            end
          end else begin
            bit_cnt <= bit_cnt + LOG2_DEC'(1);
            acc     <= count_next;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pdm_capture.sv
// Self-checking bench for pdm_capture at default parameters; expected samples are queued when capture starts.
// Define PDM_CLIP_DETECT_EN for both files to also exercise clip_o.
module tb_pdm_capture;

  localparam int WINDOW_CYCLES = 128 * 2 * 25;
  localparam int FIRST_DONE    = 3 * WINDOW_CYCLES + 1;
  localparam int SECOND_DONE   = FIRST_DONE + WINDOW_CYCLES;

  typedef struct {
    int          cyc;
    logic [15:0] sample;
  } exp_t;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        enable_i;
  logic        pdm_data_i;
  logic        pdm_clk_o;
  logic        pdm_lrsel_o;
  logic [15:0] sample_o;
  logic        done_o;
  logic        busy_o;
`ifdef PDM_CLIP_DETECT_EN
  logic        clip_o;
`endif

  logic const_bit = 1'b0;
  logic alt_mode  = 1'b0;
  logic alt_bit   = 1'b0;
  int   cyc       = 0;
  int   checks    = 0;
  int   errors    = 0;
  exp_t exp_q[$];

  pdm_capture dut (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .enable_i   (enable_i),
    .pdm_data_i (pdm_data_i),
    .pdm_clk_o  (pdm_clk_o),
    .pdm_lrsel_o(pdm_lrsel_o),
    .sample_o   (sample_o),
    .done_o     (done_o),
    .busy_o     (busy_o)
`ifdef PDM_CLIP_DETECT_EN
    ,
    .clip_o     (clip_o)
`endif
  );

  always #5 clock_i = ~clock_i;
  always @(posedge clock_i) cyc <= cyc + 1;
  always @(posedge pdm_clk_o) alt_bit <= ~alt_bit;
  assign pdm_data_i = alt_mode ? alt_bit : const_bit;

  task automatic next_cycle();
    @(posedge clock_i);
    #1;
  endtask

  task automatic test_reset();
    reset_i   = 1'b0;
    enable_i  = 1'b0;
    const_bit = 1'b0;
    alt_mode  = 1'b0;
    repeat (3) next_cycle();
    checks += 5;
    if (pdm_clk_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_pdm_clk: got %b expected 0", pdm_clk_o); end
    if (pdm_lrsel_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_lrsel: got %b expected 0", pdm_lrsel_o); end
    if (sample_o !== 16'h0000) begin errors++; $display("[TB] FAIL reset_sample: got %h expected 0000", sample_o); end
    if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done_o); end
    if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
`ifdef PDM_CLIP_DETECT_EN
    checks++;
    if (clip_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_clip: got %b expected 0", clip_o); end
`endif
    reset_i = 1'b1;
    repeat (3) next_cycle();
  endtask

  task automatic test_all_ones();
    int   e0;
    int   rel;
    int   first_rise = -1;
    int   period     = -1;
    logic prev_clk   = 1'b0;
    logic done_prev  = 1'b0;
    exp_t e;
    const_bit = 1'b1;
    alt_mode  = 1'b0;
    repeat (5) next_cycle();
    e0 = cyc;
    enable_i = 1'b1;
    exp_q.push_back('{FIRST_DONE, 16'hFFFF});
    exp_q.push_back('{SECOND_DONE, 16'hFFFF});
    for (int n = 0; n < SECOND_DONE + 200 && exp_q.size() > 0; n++) begin
      next_cycle();
      rel = cyc - e0;
      if (pdm_clk_o && !prev_clk) begin
        if (first_rise < 0) first_rise = rel;
        else if (period < 0) period = rel - first_rise;
      end
      prev_clk = pdm_clk_o;
      if (done_prev) begin
        checks++;
        if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL ones_done_width: got %b expected 0 at rel %0d", done_o, rel); end
      end
      done_prev = done_o;
      if (done_o === 1'b1) begin
        e = exp_q.pop_front();
        checks += 2;
        if (rel != e.cyc) begin errors++; $display("[TB] FAIL ones_done_cycle: got %0d expected %0d", rel, e.cyc); end
        if (sample_o !== e.sample) begin errors++; $display("[TB] FAIL ones_sample: got %h expected %h", sample_o, e.sample); end
`ifdef PDM_CLIP_DETECT_EN
        checks++;
        if (clip_o !== 1'b1) begin errors++; $display("[TB] FAIL ones_clip_set: got %b expected 1", clip_o); end
`endif
      end
    end
    checks += 2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL ones_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    if (period != 50) begin errors++; $display("[TB] FAIL ones_pdm_period: got %0d expected 50", period); end
    next_cycle();
    enable_i = 1'b0;
    repeat (5) next_cycle();
`ifdef PDM_CLIP_DETECT_EN
    checks++;
    if (clip_o !== 1'b1) begin errors++; $display("[TB] FAIL clip_sticky_idle: got %b expected 1", clip_o); end
`endif
  endtask

  task automatic test_mid_window_disable();
    int   e0;
    int   rel;
    int   done_seen = 0;
    int   clk_seen  = 0;
    exp_t e;
    alt_mode = 1'b1;
    repeat (3) next_cycle();
    e0 = cyc;
    enable_i = 1'b1;
    exp_q.push_back('{FIRST_DONE, 16'h8000});
    for (int n = 0; n < 22000; n++) begin
      next_cycle();
      rel = cyc - e0;
`ifdef PDM_CLIP_DETECT_EN
      if (rel == 1) begin
        checks++;
        if (clip_o !== 1'b0) begin errors++; $display("[TB] FAIL clip_clear_on_enable: got %b expected 0", clip_o); end
      end
`endif
      if (done_o === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL alt_unexpected_done: got done at rel %0d expected none", rel);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (rel != e.cyc) begin errors++; $display("[TB] FAIL alt_done_cycle: got %0d expected %0d", rel, e.cyc); end
          if (sample_o !== e.sample) begin errors++; $display("[TB] FAIL alt_sample: got %h expected %h", sample_o, e.sample); end
`ifdef PDM_CLIP_DETECT_EN
          checks++;
          if (clip_o !== 1'b0) begin errors++; $display("[TB] FAIL alt_clip: got %b expected 0", clip_o); end
`endif
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL alt_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    enable_i = 1'b0;
    next_cycle();
    checks += 2;
    if (pdm_clk_o !== 1'b0) begin errors++; $display("[TB] FAIL disable_pdm_clk: got %b expected 0", pdm_clk_o); end
    if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL disable_busy: got %b expected 0", busy_o); end
    for (int n = 0; n < 400; n++) begin
      next_cycle();
      if (done_o === 1'b1) done_seen++;
      if (pdm_clk_o === 1'b1) clk_seen++;
    end
    checks += 3;
    if (done_seen != 0) begin errors++; $display("[TB] FAIL disable_no_done: got %0d strobes expected 0", done_seen); end
    if (clk_seen != 0) begin errors++; $display("[TB] FAIL disable_clk_idle: got %0d high cycles expected 0", clk_seen); end
    if (sample_o !== 16'h8000) begin errors++; $display("[TB] FAIL disable_sample_hold: got %h expected 8000", sample_o); end
    alt_mode = 1'b0;
  endtask

  task automatic test_async_reset();
    int found = 0;
    const_bit = 1'b1;
    repeat (3) next_cycle();
    enable_i = 1'b1;
    for (int n = 0; n < 100 && found == 0; n++) begin
      next_cycle();
      if (pdm_clk_o === 1'b1) found = 1;
    end
    checks++;
    if (found == 0) begin errors++; $display("[TB] FAIL areset_clk_rise: got no pdm_clk_o high expected high within 100"); end
    reset_i = 1'b0;
    #1;
    checks += 4;
    if (pdm_clk_o !== 1'b0) begin errors++; $display("[TB] FAIL areset_pdm_clk: got %b expected 0", pdm_clk_o); end
    if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL areset_busy: got %b expected 0", busy_o); end
    if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL areset_done: got %b expected 0", done_o); end
    if (sample_o !== 16'h0000) begin errors++; $display("[TB] FAIL areset_sample: got %h expected 0000", sample_o); end
    enable_i = 1'b0;
    next_cycle();
    reset_i = 1'b1;
    repeat (200) next_cycle();
    checks += 3;
    if (pdm_clk_o !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_pdm_clk: got %b expected 0", pdm_clk_o); end
    if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy: got %b expected 0", busy_o); end
    if (sample_o !== 16'h0000) begin errors++; $display("[TB] FAIL post_reset_sample: got %h expected 0000", sample_o); end
  endtask

  task automatic test_zeros_and_simultaneous_disable();
    int   e0;
    int   rel;
    exp_t e;
    const_bit = 1'b0;
    repeat (3) next_cycle();
    e0 = cyc;
    enable_i = 1'b1;
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL zeros_busy_rel0: got %b expected 0", busy_o); end
    exp_q.push_back('{FIRST_DONE, 16'h0000});
    for (int n = 0; n < SECOND_DONE - 1; n++) begin
      next_cycle();
      rel = cyc - e0;
      if (rel == 1) begin
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL zeros_busy_rel1: got %b expected 1", busy_o); end
      end
      if (done_o === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL zeros_unexpected_done: got done at rel %0d expected none", rel);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (rel != e.cyc) begin errors++; $display("[TB] FAIL zeros_done_cycle: got %0d expected %0d", rel, e.cyc); end
          if (sample_o !== e.sample) begin errors++; $display("[TB] FAIL zeros_sample: got %h expected %h", sample_o, e.sample); end
`ifdef PDM_CLIP_DETECT_EN
          checks++;
          if (clip_o !== 1'b1) begin errors++; $display("[TB] FAIL zeros_clip: got %b expected 1", clip_o); end
`endif
          const_bit = 1'b1;
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL zeros_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    // The DUT sees enable low on the same edge its fourth window (all ones) ends.
    enable_i = 1'b0;
    next_cycle();
    checks += 3;
    if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL simul_done: got %b expected 0", done_o); end
    if (sample_o !== 16'h0000) begin errors++; $display("[TB] FAIL simul_sample: got %h expected 0000", sample_o); end
    if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL simul_busy: got %b expected 0", busy_o); end
    repeat (3) next_cycle();
  endtask

  initial begin
    $display("[TB] pdm_capture bench start");
    test_reset();
    test_all_ones();
    test_mid_window_disable();
    test_async_reset();
    test_zeros_and_simultaneous_disable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
